// File: rtl/bitblock_pkg.sv
// rtl/bitblock_pkg.sv - shared constants and FSM encoding for the bit-serial MAC sequencer
package bitblock_pkg;

    localparam int LW      = 5;   // request length field width
    localparam int MAX_LEN = 16;  // multiplier bits per operation
    localparam int NIBBLES = 4;   // result nibbles collected from the core

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Length 0 means a full 16-bit run; anything longer saturates.
    function automatic logic [4:0] eff_len(input logic [31:0] len);
        if (len == 32'd0 || len > 32'(MAX_LEN)) begin
            return 5'(MAX_LEN);
        end
        return len[4:0];
    endfunction

endpackage

// File: rtl/bitblock_mac_seq.sv
// rtl/bitblock_mac_seq.sv - sequences one multiply through an external 4-block bit-serial core
//
// Ports:
//   clk, rstn                    clock, async active-low reset
//   req_valid/req_ready          request handshake; req_x, req_y, req_len, req_ci operands
//   abort                        synchronous cancel, wins over everything but reset
//   core_in/yi/ppi/ci/shift/r1   drive to the core; core_out/core_co come back from it
//   res_valid/res_ready          result handshake; res_data, res_co result
//   busy                         high outside IDLE
module bitblock_mac_seq #(
    parameter int XW = 20,
    parameter int LW = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [XW-1:0] req_x,
    input  logic [15:0]   req_y,
    input  logic [LW-1:0] req_len,
    input  logic          req_ci,
    input  logic          abort,
    output logic [XW-1:0] core_in,
    output logic          core_shift,
    output logic          core_shift_r1,
    output logic          core_ppi,
    output logic          core_ci,
    output logic [3:0]    core_yi,
    input  logic [3:0]    core_out,
    input  logic          core_co,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [15:0]   res_data,
    output logic          res_co,
    output logic          busy
);
    import bitblock_pkg::*;

    state_t        state, state_nxt;
    logic [XW-1:0] x_q;
    logic [15:0]   y_q;
    logic [4:0]    len_q;
    logic [4:0]    cnt;
    logic          ci_q;
    logic          shift_r1_q;
    logic [15:0]   res_data_q;
    logic          res_co_q;
    logic          last_bit;

    assign last_bit = (cnt == len_q - 5'd1);

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (req_valid) state_nxt = ST_LOAD;
                ST_LOAD:  state_nxt = ST_RUN;
                ST_RUN:   if (last_bit) state_nxt = ST_DRAIN;
                ST_DRAIN: state_nxt = ST_DONE;
                ST_DONE:  if (res_ready) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        busy       = (state != ST_IDLE);
        res_valid  = (state == ST_DONE);
        core_in    = '0;
        core_yi    = 4'd0;
        core_ppi   = 1'b0;
        core_ci    = 1'b0;
        core_shift = 1'b0;
        case (state)
            ST_LOAD: begin
                core_in = x_q;
                core_yi = y_q[3:0];
                core_ci = ci_q;
            end
            ST_RUN: begin
                core_in  = x_q;
                core_ppi = y_q[cnt[3:0]];
                core_ci  = (cnt == 5'd0) ? ci_q : 1'b0;
                // Shift out a nibble at each block boundary and on the final bit.
                core_shift = (cnt[1:0] == 2'd3) || last_bit;
            end
            ST_DRAIN: core_in = x_q;
            default: ;
        endcase
    end

    assign core_shift_r1 = shift_r1_q;
    assign res_data      = res_data_q;
    assign res_co        = res_co_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            len_q      <= '0;
            ci_q       <= 1'b0;
            cnt        <= '0;
            shift_r1_q <= 1'b0;
            res_data_q <= '0;
            res_co_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            shift_r1_q <= abort ? 1'b0 : core_shift;
            if (abort) begin
                cnt        <= '0;
                res_data_q <= '0;
                res_co_q   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (req_valid) begin
                            x_q   <= req_x;
                            y_q   <= req_y;
                            len_q <= eff_len(32'(req_len));
                            ci_q  <= req_ci;
                        end
                    end
                    ST_LOAD: begin
                        cnt        <= '0;
                        res_data_q <= '0;
                        res_co_q   <= 1'b0;
                    end
                    ST_RUN: begin
                        if (core_shift) begin
                            res_data_q[{cnt[3:2], 2'b00} +: 4] <= core_out;
                        end
                        cnt <= cnt + 5'd1;
                    end
                    ST_DRAIN: res_co_q <= core_co;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bitblock_mac_seq.sv
// tb/tb_bitblock_mac_seq.sv - scoreboard bench for bitblock_mac_seq
module tb_bitblock_mac_seq;

    localparam int TN = 8192;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [19:0] req_x = '0;
    logic [15:0] req_y = '0;
    logic [4:0]  req_len = '0;
    logic        req_ci = 1'b0;
    logic        abort = 1'b0;
    logic [19:0] core_in;
    logic        core_shift, core_shift_r1, core_ppi, core_ci;
    logic [3:0]  core_yi;
    logic [3:0]  core_out;
    logic        core_co;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_data;
    logic        res_co;
    logic        busy;

    bitblock_mac_seq #(.XW(20), .LW(5)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_len(req_len), .req_ci(req_ci),
        .abort(abort),
        .core_in(core_in), .core_shift(core_shift), .core_shift_r1(core_shift_r1),
        .core_ppi(core_ppi), .core_ci(core_ci), .core_yi(core_yi),
        .core_out(core_out), .core_co(core_co),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_co(res_co), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stand-in core: a pre-rolled random nibble/carry per clock cycle.
    logic [3:0] out_tab [TN];
    logic       co_tab  [TN];
    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    assign core_out = out_tab[cyc & (TN - 1)];
    assign core_co  = co_tab[cyc & (TN - 1)];

    typedef struct {
        logic [15:0] data;
        logic        co;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    bit          op_active = 0;
    int          op_e0 = 0;
    logic [19:0] op_x;
    logic [15:0] op_y;
    int          op_len = 1;
    logic        op_ci;
    bit          force_low = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit shf(input int c, input int len);
        return ((c % 4) == 3) || (c == len - 1);
    endfunction

    // Monitor: per-cycle interface expectations from the op timeline, plus scoreboard on results.
    always @(negedge clk) begin : mon
        int p, c;
        logic [19:0] ein;
        logic [3:0]  eyi;
        logic        eppi, esh, eci, eshr, ebusy, erdy, evld;
        ein = '0; eyi = '0; eppi = 0; esh = 0; eci = 0; eshr = 0;
        ebusy = 0; erdy = 1; evld = 0;
        p = op_active ? (cyc - op_e0) : -1;
        if (p == 0) begin
            ein = op_x; eyi = op_y[3:0]; eci = op_ci; ebusy = 1; erdy = 0;
        end else if (p >= 1 && p <= op_len) begin
            c = p - 1;
            ein = op_x; eppi = op_y[c]; esh = shf(c, op_len);
            eci = (c == 0) ? op_ci : 1'b0;
            eshr = (c >= 1) ? shf(c - 1, op_len) : 1'b0;
            ebusy = 1; erdy = 0;
        end else if (p == op_len + 1) begin
            ein = op_x; eshr = 1; ebusy = 1; erdy = 0;
        end else if (p >= op_len + 2) begin
            evld = 1; ebusy = 1; erdy = 0;
        end
        chk("core_in", core_in, ein);
        chk("core_yi", core_yi, eyi);
        chk("core_ppi", core_ppi, eppi);
        chk("core_shift", core_shift, esh);
        chk("core_ci", core_ci, eci);
        chk("core_shift_r1", core_shift_r1, eshr);
        chk("busy", busy, ebusy);
        chk("req_ready", req_ready, erdy);
        chk("res_valid", res_valid, evld);
        if (evld) begin
            if (exp_q.size() == 0) begin
                chk("scoreboard_empty", 1, 0);
            end else begin
                chk("res_data", res_data, exp_q[0].data);
                chk("res_co", res_co, exp_q[0].co);
                if (res_valid && res_ready) begin
                    void'(exp_q.pop_front());
                    op_active = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            res_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue(input logic [19:0] x, input logic [15:0] y,
                         input logic [4:0] len, input logic ci);
        int   len_e, c;
        exp_t e;
        @(posedge clk);
        #2;
        len_e = (len == 0 || len > 16) ? 16 : int'(len);
        chk("req_ready_at_issue", req_ready, 1);
        req_x = x; req_y = y; req_len = len; req_ci = ci; req_valid = 1;
        op_e0 = cyc + 1;
        op_x = x; op_y = y; op_len = len_e; op_ci = ci;
        e.data = '0;
        for (int k = 0; k < 4; k++) begin
            if (4 * k < len_e) begin
                c = (4 * k + 3 < len_e - 1) ? 4 * k + 3 : len_e - 1;
                e.data[4 * k +: 4] = out_tab[(op_e0 + 1 + c) & (TN - 1)];
            end
        end
        e.co = co_tab[(op_e0 + 1 + len_e) & (TN - 1)];
        exp_q.push_back(e);
        op_active = 1;
        @(posedge clk);
        #2;
        req_valid = 0;
        req_x = 20'($urandom); req_y = 16'($urandom); req_len = 5'($urandom); req_ci = 1'($urandom);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300 && op_active; i++) @(posedge clk);
        if (op_active) begin
            n_cmp++;
            n_bad++;
            $display("FAIL op_timeout: result still pending, required completion by cycle %0d", cyc);
            op_active = 0;
            exp_q.delete();
        end
        @(posedge clk);
    endtask

    task automatic wait_cyc(input int target);
        for (int i = 0; i < 300; i++) begin
            if (cyc >= target) break;
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_res_data"}, res_data, 0);
        chk({tag, "_res_co"}, res_co, 0);
        chk({tag, "_core_in"}, core_in, 0);
        chk({tag, "_core_ctl"}, {core_shift, core_shift_r1, core_ppi, core_ci, core_yi}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < TN; i++) begin
            out_tab[i] = 4'($urandom);
            co_tab[i]  = 1'($urandom);
        end
        #3;
        chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        #2;
        rstn = 1;

        issue(20'h12345, 16'h000B, 5'd4, 1'b1);
        wait_done();
        issue(20'h0ABCD, 16'h2D, 5'd6, 1'b0);
        wait_done();
        issue(20'hFFFFF, 16'hA5C3, 5'd0, 1'b1);
        wait_done();
        issue(20'h13579, 16'h8001, 5'd20, 1'b0);
        wait_done();
        issue(20'h00001, 16'h0001, 5'd1, 1'b1);
        wait_done();

        // Result held back for 10 cycles in DONE.
        force_low = 1;
        issue(20'h55AA5, 16'h1234, 5'd9, 1'b1);
        wait_cyc(op_e0 + op_len + 2 + 10);
        force_low = 0;
        wait_done();

        // Abort while RUN is at bit 2.
        issue(20'h24680, 16'hBEEF, 5'd8, 1'b1);
        wait_cyc(op_e0 + 3);
        abort = 1;
        @(posedge clk);
        #2;
        abort = 0;
        op_active = 0;
        void'(exp_q.pop_back());
        chk("abort_busy", busy, 0);
        chk("abort_req_ready", req_ready, 1);
        repeat (3) @(posedge clk);
        issue(20'h11111, 16'h00F3, 5'd7, 1'b0);
        wait_done();

        // Reset while RUN is at bit 5.
        issue(20'h0F0F0, 16'hCAFE, 5'd12, 1'b1);
        wait_cyc(op_e0 + 6);
        #1;
        rstn = 0;
        op_active = 0;
        void'(exp_q.pop_back());
        #1;
        chk_reset_vals("midrun_reset");
        @(posedge clk);
        #2;
        rstn = 1;
        issue(20'h12345, 16'h000B, 5'd4, 1'b0);
        wait_done();

        for (int n = 0; n < 30; n++) begin
            issue(20'($urandom), 16'($urandom), 5'($urandom_range(0, 20)), 1'($urandom));
            wait_done();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bitblock_mac_seq.md
BITBLOCK_MAC_SEQ -- requirements
Module: bitblock_mac_seq

Interface
REQ-001 SHALL have parameter XW, default 20: multiplicand bus width, matching the core's 5 bits x 4 blocks.
REQ-002 SHALL have parameter LW, default 5: width of the length field; maximum length is 16 multiplier bits.
REQ-003 SHALL have port clk, input, 1: clock, rising edge.
REQ-004 SHALL have port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid / req_ready, input / output, 1 / 1: operation request handshake.
REQ-006 SHALL have port req_x, input, XW: multiplicand image for core in.
REQ-007 SHALL have port req_y, input, 16: multiplier, fed LSB first.
REQ-008 SHALL have port req_len, input, LW: multiplier bit count; 0 is treated as 16; values above 16 saturate to 16.
REQ-009 SHALL have port req_ci, input, 1: carry-in for the operation.
REQ-010 SHALL have port abort, input, 1: synchronous cancel.
REQ-011 SHALL have outputs core_in (XW), core_shift, core_shift_r1, core_ppi, core_ci (1 each), and core_yi (4): drive the 4-block core.
REQ-012 SHALL have inputs core_out (4) and core_co (1): core result nibble and registered carry.
REQ-013 SHALL have port res_valid / res_ready, output / input, 1 / 1: result handshake.
REQ-014 SHALL have outputs res_data (16) and res_co (1): collected result and final carry.
REQ-015 SHALL have output busy, 1: high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, RUN, DRAIN, DONE.
REQ-017 SHALL hold req_ready = 1 only in IDLE; on req_valid & req_ready it SHALL capture x, y, effective len and ci, then go to LOAD.
REQ-018 LOAD SHALL last 1 cycle, with core_in = x, core_yi = y[3:0], core_ppi = 0, core_shift = 0, core_ci = ci; bit counter cnt = 0 and res_data SHALL be cleared.
REQ-019 RUN SHALL last exactly len cycles, with cnt counting 0..len-1, core_ppi = y[cnt], and core_ci = 0 after the first RUN cycle.
REQ-020 core_shift SHALL be 1 in RUN when cnt[1:0] == 3 or cnt == len-1, and 0 in every other state.
REQ-021 core_shift_r1 SHALL be core_shift registered one cycle, forced to 0 in IDLE.
REQ-022 On each RUN cycle with core_shift = 1, core_out SHALL be written to res_data[4k+3:4k] with k = cnt>>2; unwritten nibbles SHALL remain 0.
REQ-023 DRAIN SHALL last 1 cycle: core_co is sampled into res_co, then the FSM moves to DONE.
REQ-024 In DONE, res_valid SHALL be 1 and res_data/res_co stable until res_ready; the cycle after res_valid & res_ready the FSM SHALL return to IDLE.
REQ-025 Latency: request accepted at edge E0 -> res_valid high from edge E0+len+2.
REQ-026 core_in SHALL hold x from LOAD through DRAIN and be 0 in IDLE and DONE.
REQ-027 abort SHALL force IDLE at the next edge from any state, clear res_valid and core_shift_r1, and discard the result; abort has priority over an accept in the same cycle.
REQ-028 An accept in the same cycle as a DONE completion SHALL NOT occur, because req_ready is low in DONE.

Reset
REQ-029 While rstn = 0, the block SHALL hold state IDLE; cnt, res_data, res_co, res_valid, core_shift_r1 and all core_* outputs = 0; req_ready = 1; busy = 0.
REQ-030 Reset asserted mid-operation SHALL take effect immediately, and the in-flight result SHALL be lost.

Structure
REQ-031 Package bitblock_pkg SHALL hold the FSM state encoding (3 bits), LW, the maximum length 16, and the nibble count 4.
REQ-032 The core SHALL be instantiated by the parent, not inside this block; this block SHALL contain no sub-module.

Verification
REQ-033 len=4, y=0xB, x=0x12345: core_ppi sequence 1,1,0,1; core_shift only at cnt 3; core_shift_r1 one cycle later; res_valid at E0+6.
REQ-034 len=6: core_shift at cnt 3 and 5; res_data[7:0] holds the two sampled nibbles; res_data[15:8] = 0.
REQ-035 len=0: runs 16 cycles, 4 shift pulses, and all res_data nibbles are written.
REQ-036 res_ready held low 10 cycles in DONE: res_valid, res_data and res_co stay stable; req_ready stays 0 throughout.
REQ-037 abort at RUN cnt=2: IDLE next cycle, res_valid never asserts, and a following request completes normally.
REQ-038 rstn low at RUN cnt=5: all outputs are at their REQ-029 values immediately; the first request after release behaves as in REQ-033.
